ir_sense_sched: RTL
===================

IR_SENSE_SCHED -- requirements
Module: ir_sense_sched

Interface
REQ-001 SHALL have parameter PERIOD, default 1024: cycles between sample sequences (range 64..65535).
REQ-002 SHALL have parameter SETTLE, default 32: cycles IR emitters are on before the first conversion (range 1..255).
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for one conversion (range 2..255).
REQ-004 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  enables periodic sampling.
REQ-007 SHALL have port IR_en  output  1  IR emitter enable.
REQ-008 SHALL have port a2d_strt  output  1  one-cycle conversion start pulse.
REQ-009 SHALL have port a2d_chnnl  output  3  channel under conversion.
REQ-010 SHALL have port a2d_cnv_done  input  1  conversion complete strobe.
REQ-011 SHALL have port a2d_res  input  12  conversion result, valid with a2d_cnv_done.
REQ-012 SHALL have port sel  input  3  read index into the result file.
REQ-013 SHALL have port ir_val  output  12  result file entry [sel], combinational.
REQ-014 SHALL have port IR_vld  output  1  one-cycle pulse: new set of 8 results ready.
REQ-015 SHALL have port a2d_err  output  1  sticky, set on any conversion timeout in current sequence.

Function
REQ-016 SHALL run a 16-bit period counter: counts while en=1, cleared while en=0; on reaching PERIOD-1 asserts internal tick for 1 cycle and wraps to 0.
REQ-017 SHALL implement states IDLE, SETTLE, START, WAIT, NEXT, DONE.
REQ-018 IDLE: on tick -> SETTLE, clear a2d_err, channel index := 0, settle count := 0; otherwise stay.
REQ-019 SETTLE: IR_en=1; count SETTLE cycles, then -> START.
REQ-020 START: IR_en=1, a2d_strt=1 for exactly one cycle, timeout count := 0, -> WAIT.
REQ-021 WAIT: IR_en=1; on a2d_cnv_done write a2d_res into entry [channel] at that edge, -> NEXT.
REQ-022 WAIT timeout: if TIMEOUT cycles elapse without a2d_cnv_done, write 12'hFFF into entry [channel], set a2d_err, -> NEXT.
REQ-023 NEXT: IR_en=1; channel 7 -> DONE; else channel+1, -> START.
REQ-024 DONE: IR_en=0, IR_vld=1 for one cycle, -> IDLE.
REQ-025 a2d_chnnl SHALL equal the channel index at all times, 3'd0 in IDLE.
REQ-026 a2d_cnv_done outside WAIT SHALL be ignored: no write, no state change.
REQ-027 a2d_cnv_done in the same cycle the timeout expires SHALL be treated as done: result stored, a2d_err unchanged.
REQ-028 ticks arriving outside IDLE SHALL be dropped; period counter keeps running.
REQ-029 en deasserted mid-sequence SHALL not abort; sequence completes through DONE, then IDLE holds.
REQ-030 result file entries SHALL hold their value until overwritten; ir_val reflects a write on the cycle after the write edge.
REQ-031 tick-to-first-a2d_strt latency SHALL be SETTLE+1 cycles; no-wait sequence length (done on first WAIT cycle) SHALL be 1+SETTLE+8*3+1 cycles.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state IDLE, period counter 0, channel 0, all 8 result entries 12'h000, IR_en=0, a2d_strt=0, IR_vld=0, a2d_err=0.
REQ-033 reset mid-sequence SHALL abandon the sequence with no IR_vld; first tick after release starts a fresh sequence.

Verification
REQ-034 PERIOD=64, SETTLE=4, en=1 from reset, model returns done 3 cycles after strt with res=100*chnl -> first strt at cycle 64+4+1 from count start, IR_vld once, ir_val[sel=5]=500, a2d_err=0.
REQ-035 model never answers channel 2, TIMEOUT=10 -> entry 2 = 12'hFFF, a2d_err=1 until next sequence start, other entries correct, IR_vld still pulses.
REQ-036 spurious a2d_cnv_done with res=12'hABC during SETTLE and IDLE -> no entry changes, no state change.
REQ-037 en dropped during channel 3 WAIT -> sequence finishes, IR_vld pulses, no further strt while en=0; re-assert en -> next strt after 64+4+1 cycles.
REQ-038 rst_n pulsed low during channel 6 WAIT -> outputs zero immediately, all entries 12'h000, no IR_vld until a complete later sequence.
REQ-039 done coincident with timeout expiry on channel 0 -> result stored, a2d_err=0.

Source files
------------

// File: rtl/ir_sense_sched.sv
// IR proximity sense scheduler: periodically powers the IR emitters, converts
// all eight A2D channels in turn and keeps the latest results in a small file.
module ir_sense_sched #(
   parameter int PERIOD  = 1024,
   parameter int SETTLE  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        IR_en,
   output logic        a2d_strt,
   output logic [2:0]  a2d_chnnl,
   input  logic        a2d_cnv_done,
   input  logic [11:0] a2d_res,
   input  logic [2:0]  sel,
   output logic [11:0] ir_val,
   output logic        IR_vld,
   output logic        a2d_err
);

   localparam logic [15:0] LP_PER_LAST = 16'(PERIOD - 1);
   localparam logic [7:0]  LP_SET_LAST = 8'(SETTLE - 1);
   localparam logic [7:0]  LP_TO_LAST  = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_START,
      S_WAIT,
      S_NEXT,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [15:0] r_perCnt;
   logic [7:0]  r_setCnt;
   logic [7:0]  r_toCnt;
   logic [2:0]  r_chnl;
   logic        r_irEn;
   logic        r_strt;
   logic        r_vld;
   logic        r_err;
   logic [11:0] r_res [8];
   logic        w_tick;

   // The period counter only advances while sampling is enabled.
   assign w_tick = en && (r_perCnt == LP_PER_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perCnt <= '0;
      end else if (!en || w_tick) begin
         r_perCnt <= '0;
      end else begin
         r_perCnt <= r_perCnt + 16'd1;
      end
   end

   // Outputs are set on the edge entering the state that owns them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_setCnt <= '0;
         r_toCnt  <= '0;
         r_chnl   <= '0;
         r_irEn   <= 1'b0;
         r_strt   <= 1'b0;
         r_vld    <= 1'b0;
         r_err    <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_res[i] <= '0;
         end
      end else begin
         r_strt <= 1'b0;
         r_vld  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_tick) begin
                  r_state  <= S_SETTLE;
                  r_err    <= 1'b0;
                  r_chnl   <= '0;
                  r_setCnt <= '0;
                  r_irEn   <= 1'b1;
               end
            end
            S_SETTLE: begin
               if (r_setCnt == LP_SET_LAST) begin
                  r_state <= S_START;
                  r_strt  <= 1'b1;
               end else begin
                  r_setCnt <= r_setCnt + 8'd1;
               end
            end
            S_START: begin
               r_toCnt <= '0;
               r_state <= S_WAIT;
            end
            // A done arriving on the final timeout cycle still wins.
            S_WAIT: begin
               if (a2d_cnv_done) begin
                  r_res[r_chnl] <= a2d_res;
                  r_state       <= S_NEXT;
               end else if (r_toCnt == LP_TO_LAST) begin
                  r_res[r_chnl] <= 12'hFFF;
                  r_err         <= 1'b1;
                  r_state       <= S_NEXT;
               end else begin
                  r_toCnt <= r_toCnt + 8'd1;
               end
            end
            S_NEXT: begin
               if (r_chnl == 3'd7) begin
                  r_state <= S_DONE;
                  r_irEn  <= 1'b0;
                  r_vld   <= 1'b1;
               end else begin
                  r_chnl  <= r_chnl + 3'd1;
                  r_state <= S_START;
                  r_strt  <= 1'b1;
               end
            end
            S_DONE: begin
               r_chnl  <= '0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_irEn  <= 1'b0;
               r_chnl  <= '0;
            end
         endcase
      end
   end

   assign IR_en     = r_irEn;
   assign a2d_strt  = r_strt;
   assign a2d_chnnl = r_chnl;
   assign IR_vld    = r_vld;
   assign a2d_err   = r_err;
   assign ir_val    = r_res[sel];

endmodule
